// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the control unit: opcodes and controller state encoding.
package unidade_controle_pkg;

  localparam logic [2:0] OP_CARREGA_A = 3'b000;
  localparam logic [2:0] OP_CARREGA_B = 3'b001;
  localparam logic [2:0] OP_SOMA      = 3'b010;
  localparam logic [2:0] OP_SUB       = 3'b011;
  localparam logic [2:0] OP_PARA      = 3'b100;

  typedef enum logic [1:0] {
    OCIOSO  = 2'b00,
    BUSCA   = 2'b01,
    EXECUTA = 2'b10,
    PARADO  = 2'b11
  } estado_t;

endpackage

// File: rtl/unidade_controle_ula.sv
// Combinational ALU: 5-bit sum, and modulo-16 difference with a borrow flag.
module unidade_controle_ula (
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [4:0] soma,
  output logic [3:0] diferenca,
  output logic       emprestimo
);

  always_comb begin
    soma       = {1'b0, a} + {1'b0, b};
    diferenca  = a - b;
    emprestimo = (a < b);
  end

endmodule

// File: rtl/unidade_controle.sv
// Two-cycle fetch/execute controller driving an external registered program memory.
//
// state   | meaning
// OCIOSO  | idle after reset, waiting for iniciar
// BUSCA   | address presented, memory registering the instruction
// EXECUTA | instruction visible on instrucao/valor, decoded at exit edge
// PARADO  | halted after OP_PARA, waiting for iniciar to restart
module unidade_controle
  import unidade_controle_pkg::*;
#(
  parameter logic [3:0] PC_INICIAL = 4'b0000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       iniciar,
  input  logic [2:0] instrucao,
  input  logic [3:0] valor,
  output logic [3:0] posicaoMemoria,
  output logic [3:0] regA,
  output logic [3:0] regB,
  output logic [3:0] resultado,
  output logic       carry,
  output logic       ocupado,
  output logic       concluido
);

  estado_t    estado;
  logic [4:0] soma;
  logic [3:0] diferenca;
  logic       emprestimo;

  unidade_controle_ula u_ula (
    .a          (regA),
    .b          (regB),
    .soma       (soma),
    .diferenca  (diferenca),
    .emprestimo (emprestimo)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      estado         <= OCIOSO;
      posicaoMemoria <= 4'd0;
      regA           <= 4'd0;
      regB           <= 4'd0;
      resultado      <= 4'd0;
      carry          <= 1'b0;
      ocupado        <= 1'b0;
      concluido      <= 1'b0;
    end else begin
      case (estado)
        OCIOSO, PARADO: begin
          if (iniciar) begin
            estado         <= BUSCA;
            posicaoMemoria <= PC_INICIAL;
            ocupado        <= 1'b1;
            concluido      <= 1'b0;
          end
        end
        BUSCA: estado <= EXECUTA;
        EXECUTA: begin
          if (instrucao == OP_PARA) begin
            estado    <= PARADO;
            ocupado   <= 1'b0;
            concluido <= 1'b1;
          end else begin
            estado         <= BUSCA;
            posicaoMemoria <= posicaoMemoria + 4'd1;
            case (instrucao)
              OP_CARREGA_A: regA <= valor;
              OP_CARREGA_B: regB <= valor;
              OP_SOMA:      {carry, resultado} <= soma;
              OP_SUB: begin
                resultado <= diferenca;
                carry     <= emprestimo;
              end
              default: ;
            endcase
          end
        end
        default: estado <= OCIOSO;
      endcase
    end
  end

endmodule

// File: tb/tb_unidade_controle.sv
// Bench for unidade_controle: registered program memory, instruction-level model, directed + random runs.
module tb_unidade_controle;

  localparam int PC0 = 0;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       iniciar = 1'b0;
  logic [2:0] instrucao = 3'd0;
  logic [3:0] valor = 4'd0;
  logic [3:0] posicaoMemoria, regA, regB, resultado;
  logic       carry, ocupado, concluido;

  logic [2:0] mem_op [16];
  logic [3:0] mem_val[16];

  int  n_aval = 0;
  int  n_falhas = 0;
  bit  ativo = 1'b0;

  // model: fase 0 idle, 1 fetch, 2 execute, 3 halted
  int m_fase = 0, m_pc = 0, m_a = 0, m_b = 0, m_res = 0, m_carry = 0;
  int m_op, m_v, m_s;

  unidade_controle #(.PC_INICIAL(4'b0000)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .iniciar        (iniciar),
    .instrucao      (instrucao),
    .valor          (valor),
    .posicaoMemoria (posicaoMemoria),
    .regA           (regA),
    .regB           (regB),
    .resultado      (resultado),
    .carry          (carry),
    .ocupado        (ocupado),
    .concluido      (concluido)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    instrucao <= mem_op[posicaoMemoria];
    valor     <= mem_val[posicaoMemoria];
  end

  always @(posedge clock) begin
    if (!reset_n) begin
      m_fase = 0; m_pc = 0; m_a = 0; m_b = 0; m_res = 0; m_carry = 0;
    end else if (m_fase == 0 || m_fase == 3) begin
      if (iniciar) begin
        m_fase = 1;
        m_pc = PC0;
      end
    end else if (m_fase == 1) begin
      m_fase = 2;
    end else begin
      m_op = int'(mem_op[m_pc]);
      m_v  = int'(mem_val[m_pc]);
      if (m_op == 4) begin
        m_fase = 3;
      end else begin
        if (m_op == 0) m_a = m_v;
        else if (m_op == 1) m_b = m_v;
        else if (m_op == 2) begin
          m_s = m_a + m_b;
          m_res = m_s % 16;
          m_carry = (m_s > 15) ? 1 : 0;
        end else if (m_op == 3) begin
          m_res = (m_a - m_b + 16) % 16;
          m_carry = (m_a < m_b) ? 1 : 0;
        end
        m_pc = (m_pc + 1) % 16;
        m_fase = 1;
      end
    end
  end

  always @(negedge clock) begin
    if (ativo) begin
      n_aval++;
      if (int'(posicaoMemoria) != m_pc || int'(regA) != m_a || int'(regB) != m_b ||
          int'(resultado) != m_res || int'(carry) != m_carry ||
          ocupado != (m_fase == 1 || m_fase == 2) || concluido != (m_fase == 3)) begin
        n_falhas++;
        $display("FAIL ciclo t=%0t: pc=%0d/%0d A=%0d/%0d B=%0d/%0d res=%0d/%0d c=%0d/%0d oc=%0d con=%0d fase=%0d",
                 $time, posicaoMemoria, m_pc, regA, m_a, regB, m_b, resultado, m_res,
                 carry, m_carry, ocupado, concluido, m_fase);
      end
    end
  end

  task automatic verifica(input string nome, input int atual, input int esperado);
    n_aval++;
    if (atual != esperado) begin
      n_falhas++;
      $display("FAIL %s: obtido=%0d esperado=%0d", nome, atual, esperado);
    end
  endtask

  task automatic ciclos(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic grava(input int addr, input int op, input int v);
    mem_op[addr]  = 3'(op);
    mem_val[addr] = 4'(v);
  endtask

  task automatic programa(input int a, input int b, input int op);
    grava(0, 0, a);
    grava(1, 1, b);
    grava(2, op, 0);
    grava(3, 4, 0);
  endtask

  task automatic pulso_iniciar();
    iniciar = 1'b1;
    ciclos(1);
    iniciar = 1'b0;
  endtask

  task automatic espera_fim();
    int k = 0;
    while (!concluido && k < 200) begin
      ciclos(1);
      k++;
    end
    verifica("espera_concluido", int'(concluido), 1);
  endtask

  initial begin
    logic [3:0] sa, sb, sr;
    for (int i = 0; i < 16; i++) grava(i, 5, i);

    reset_n = 1'b0;
    ciclos(2);
    reset_n = 1'b1;
    ativo = 1'b1;
    verifica("reset_pc", int'(posicaoMemoria), 0);
    verifica("reset_regA", int'(regA), 0);
    verifica("reset_ocupado", int'(ocupado), 0);
    verifica("reset_concluido", int'(concluido), 0);

    // addition program, iniciar sampled at E0
    programa(3, 5, 2);
    pulso_iniciar();
    verifica("soma_E0_ocupado", int'(ocupado), 1);
    verifica("soma_E0_pc", int'(posicaoMemoria), 0);
    ciclos(2);
    verifica("soma_E2_regA", int'(regA), 3);
    verifica("soma_E2_modelo", m_a, 3);
    ciclos(2);
    verifica("soma_E4_regB", int'(regB), 5);
    ciclos(2);
    verifica("soma_E6_resultado", int'(resultado), 8);
    verifica("soma_E6_carry", int'(carry), 0);
    verifica("soma_E6_modelo", m_res, 8);
    ciclos(2);
    verifica("soma_E8_concluido", int'(concluido), 1);
    verifica("soma_E8_ocupado", int'(ocupado), 0);

    // restart from PARADO keeps resultado
    programa(9, 9, 2);
    pulso_iniciar();
    verifica("reinicio_pc", int'(posicaoMemoria), 0);
    verifica("reinicio_ocupado", int'(ocupado), 1);
    verifica("reinicio_resultado", int'(resultado), 8);
    espera_fim();
    verifica("carry_resultado", int'(resultado), 2);
    verifica("carry_flag", int'(carry), 1);

    programa(2, 5, 3);
    pulso_iniciar();
    espera_fim();
    verifica("emprestimo_resultado", int'(resultado), 13);
    verifica("emprestimo_flag", int'(carry), 1);
    verifica("emprestimo_modelo", m_res, 13);

    programa(5, 2, 3);
    pulso_iniciar();
    espera_fim();
    verifica("sub_resultado", int'(resultado), 3);
    verifica("sub_flag", int'(carry), 0);

    // NOP sweep across the whole address space and wrap
    for (int i = 0; i < 16; i++) grava(i, 5 + (i % 3), $urandom_range(0, 15));
    sa = regA; sb = regB; sr = resultado;
    pulso_iniciar();
    ciclos(30);
    verifica("nop_pc15", int'(posicaoMemoria), 15);
    verifica("nop_ocupado15", int'(ocupado), 1);
    ciclos(2);
    verifica("nop_wrap_pc", int'(posicaoMemoria), 0);
    verifica("nop_wrap_ocupado", int'(ocupado), 1);
    verifica("nop_regA", int'(regA), int'(sa));
    verifica("nop_regB", int'(regB), int'(sb));
    verifica("nop_resultado", int'(resultado), int'(sr));

    // reset during EXECUTA of a load, with iniciar held at that edge
    reset_n = 1'b0;
    ciclos(1);
    reset_n = 1'b1;
    grava(0, 0, 7);
    pulso_iniciar();
    ciclos(1);
    reset_n = 1'b0;
    iniciar = 1'b1;
    ciclos(1);
    reset_n = 1'b1;
    iniciar = 1'b0;
    verifica("rst_meio_regA", int'(regA), 0);
    verifica("rst_meio_pc", int'(posicaoMemoria), 0);
    verifica("rst_meio_ocupado", int'(ocupado), 0);
    ciclos(1);
    verifica("rst_meio_ocioso", int'(ocupado), 0);

    for (int i = 0; i < 16; i++) grava(i, $urandom_range(0, 7), $urandom_range(0, 15));
    for (int it = 0; it < 3000; it++) begin
      reset_n = ($urandom_range(0, 99) != 0);
      iniciar = ($urandom_range(0, 3) == 0);
      if ((m_fase == 0 || m_fase == 3) && $urandom_range(0, 3) == 0)
        grava($urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 15));
      ciclos(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_aval, n_falhas);
    $finish;
  end

endmodule
